instr_fetch: RTL and testbench

Instruction-fetch stage sitting directly downstream of the program counter register. Each cycle it reads the instruction addressed by the registered PC from a loadable instruction memory, computes the following PC (sequential, branch target or hold), and loads the IF/ID pipeline register. It also detects the HALT instruction and raises a sticky `halted` flag that drives the program counter's `stop` input.

---
 rtl/instr_fetch.sv | 111 +++++++++++
 tb/tb_instr_fetch.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: asynchronous-read instruction memory, next-PC selection,
// IF/ID pipeline register and a sticky HALT flag that stops the program counter.
module instr_fetch #(
   parameter int          WIDTH       = 8,
   parameter int          INSTR_WIDTH = 32,
   parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [WIDTH-1:0]       pc_in,
   input  logic                   stall,
   input  logic                   branch_taken,
   input  logic [WIDTH-1:0]       branch_target,
   input  logic                   wr_en,
   input  logic [WIDTH-1:0]       wr_addr,
   input  logic [INSTR_WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0]       pc_next,
   output logic [INSTR_WIDTH-1:0] ifid_instr,
   output logic [WIDTH-1:0]       ifid_pc_plus1,
   output logic                   ifid_valid,
   output logic                   halted,
   output logic [15:0]            fetch_count
);

   localparam int DEPTH = 1 << WIDTH;

   logic [INSTR_WIDTH-1:0] mem [DEPTH];

   logic [INSTR_WIDTH-1:0] f_instr;
   logic [WIDTH-1:0]       f_pc1;
   logic                   f_is_halt;

   logic [INSTR_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
   logic [WIDTH-1:0]       ifid_pc_plus1_q, ifid_pc_plus1_d;
   logic                   ifid_valid_q, ifid_valid_d;
   logic                   halted_q, halted_d;
   logic [15:0]            fetch_count_q, fetch_count_d;

   // NOTE: the memory is deliberately not reset; the loader fills it, and writes
   // must land even while the pipeline registers are held in reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Asynchronous read: a same-cycle write to pc_in is not yet visible here.
   always_comb begin
      f_instr   = mem[pc_in];
      f_pc1     = pc_in + WIDTH'(1);
      f_is_halt = (f_instr[INSTR_WIDTH-1 -: 6] == HALT_OPCODE);
   end

   // NOTE: every signal written below is given a default first, so no branch of the
   // priority chain can leave one unassigned and infer a latch.
   always_comb begin
      pc_next         = pc_in;
      ifid_instr_d    = ifid_instr_q;
      ifid_pc_plus1_d = ifid_pc_plus1_q;
      ifid_valid_d    = ifid_valid_q;
      halted_d        = halted_q;
      fetch_count_d   = fetch_count_q;

      if (branch_taken) begin
         pc_next         = branch_target;
         ifid_instr_d    = '0;
         ifid_pc_plus1_d = '0;
         ifid_valid_d    = 1'b0;
         halted_d        = 1'b0;
      end else if (halted_q) begin
         ifid_instr_d    = '0;
         ifid_pc_plus1_d = '0;
         ifid_valid_d    = 1'b0;
      end else if (!stall) begin
         pc_next         = f_pc1;
         ifid_instr_d    = f_instr;
         ifid_pc_plus1_d = f_pc1;
         ifid_valid_d    = 1'b1;
         fetch_count_d   = fetch_count_q + 16'd1;
         // The HALT itself is passed on as a valid instruction so it drains downstream.
         if (f_is_halt) begin
            halted_d = 1'b1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples the
   // values computed before this edge, independent of block evaluation order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ifid_instr_q    <= '0;
         ifid_pc_plus1_q <= '0;
         ifid_valid_q    <= 1'b0;
         halted_q        <= 1'b0;
         fetch_count_q   <= '0;
      end else begin
         ifid_instr_q    <= ifid_instr_d;
         ifid_pc_plus1_q <= ifid_pc_plus1_d;
         ifid_valid_q    <= ifid_valid_d;
         halted_q        <= halted_d;
         fetch_count_q   <= fetch_count_d;
      end
   end

   assign ifid_instr    = ifid_instr_q;
   assign ifid_pc_plus1 = ifid_pc_plus1_q;
   assign ifid_valid    = ifid_valid_q;
   assign halted        = halted_q;
   assign fetch_count   = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_instr_fetch;

   localparam int W  = 8;
   localparam int IW = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [W-1:0]  pc_in = '0;
   logic          stall = 1'b0;
   logic          branch_taken = 1'b0;
   logic [W-1:0]  branch_target = '0;
   logic          wr_en = 1'b0;
   logic [W-1:0]  wr_addr = '0;
   logic [IW-1:0] wr_data = '0;

   logic [W-1:0]  pc_next;
   logic [IW-1:0] ifid_instr;
   logic [W-1:0]  ifid_pc_plus1;
   logic          ifid_valid;
   logic          halted;
   logic [15:0]   fetch_count;

   instr_fetch #(.WIDTH(W), .INSTR_WIDTH(IW), .HALT_OPCODE(6'h3F)) dut (
      .clk           (clk),
      .reset         (reset),
      .pc_in         (pc_in),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .pc_next       (pc_next),
      .ifid_instr    (ifid_instr),
      .ifid_pc_plus1 (ifid_pc_plus1),
      .ifid_valid    (ifid_valid),
      .halted        (halted),
      .fetch_count   (fetch_count)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: memory array, IF/ID contents, flags, and the program counter
   // that sits upstream (captures pc_next unless stopped by halted, redirects always).
   logic [IW-1:0] m_mem [256];
   logic [IW-1:0] m_instr = '0;
   logic [W-1:0]  m_pc1 = '0;
   logic          m_valid = 1'b0;
   logic          m_halted = 1'b0;
   logic [15:0]   m_count = '0;
   logic [W-1:0]  m_pc = '0;
   logic [IW-1:0] m_f;
   logic [W-1:0]  m_pn;
   logic          m_stop;
   bit            cmp_on = 1'b0;
   bit            follow = 1'b1;

   function automatic logic [W-1:0] model_pc_next();
      if (branch_taken)            return branch_target;
      else if (m_halted || stall)  return pc_in;
      else                         return W'(pc_in + 1);
   endfunction

   always @(posedge clk) begin
      m_f    = m_mem[pc_in];
      m_pn   = model_pc_next();
      m_stop = m_halted;
      if (!reset) begin
         m_instr = '0; m_pc1 = '0; m_valid = 1'b0; m_halted = 1'b0; m_count = '0;
      end else if (branch_taken) begin
         m_instr = '0; m_pc1 = '0; m_valid = 1'b0; m_halted = 1'b0;
      end else if (m_halted) begin
         m_instr = '0; m_pc1 = '0; m_valid = 1'b0;
      end else if (!stall) begin
         m_instr = m_f;
         m_pc1   = W'(pc_in + 1);
         m_valid = 1'b1;
         m_count = m_count + 16'd1;
         if (m_f[31:26] == 6'h3F) m_halted = 1'b1;
      end
      if (!reset)                     m_pc = '0;
      else if (branch_taken || !m_stop) m_pc = m_pn;
      if (wr_en) m_mem[wr_addr] = wr_data;
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         check("pc_next",       pc_next,       model_pc_next());
         check("ifid_instr",    ifid_instr,    m_instr);
         check("ifid_pc_plus1", ifid_pc_plus1, m_pc1);
         check("ifid_valid",    ifid_valid,    m_valid);
         check("halted",        halted,        m_halted);
         check("fetch_count",   fetch_count,   m_count);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (follow) pc_in = m_pc;
   endtask

   task automatic restart();
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   initial begin
      logic [IW-1:0] v;

      // Load the whole memory while held in reset; fillers never carry the HALT opcode.
      for (int a = 0; a < 256; a++) begin
         tick();
         cmp_on = 1'b1;
         case (a)
            0:       v = 32'h1111_1111;
            1:       v = 32'h2222_2222;
            2:       v = 32'h3333_3333;
            3:       v = 32'hFC00_0000;
            5:       v = 32'h5555_5555;
            8'h10:   v = 32'h1010_1010;
            8'h40:   v = 32'h4040_4040;
            default: v = $urandom & 32'hFBFF_FFFF;
         endcase
         wr_en = 1'b1; wr_addr = W'(a); wr_data = v;
      end
      tick();
      check("reset_valid", ifid_valid, 1'b0);
      check("reset_count", fetch_count, 16'd0);
      wr_en = 1'b0;
      reset = 1'b1;

      // Straight-line program ending in HALT.
      tick();
      check("p0_instr", ifid_instr, 32'h1111_1111);
      check("p0_pc1", ifid_pc_plus1, 8'd1);
      check("p0_valid", ifid_valid, 1'b1);
      tick();
      check("p1_instr", ifid_instr, 32'h2222_2222);
      check("p1_pc1", ifid_pc_plus1, 8'd2);
      tick();
      check("p2_instr", ifid_instr, 32'h3333_3333);
      check("p2_pc1", ifid_pc_plus1, 8'd3);
      tick();
      check("halt_instr", ifid_instr, 32'hFC00_0000);
      check("halt_pc1", ifid_pc_plus1, 8'd4);
      check("halt_valid", ifid_valid, 1'b1);
      check("halt_flag", halted, 1'b1);
      check("halt_count", fetch_count, 16'd4);
      tick();
      #1;
      check("halted_bubble", ifid_valid, 1'b0);
      check("halted_hold_pc", pc_next, 8'd4);
      check("halted_count", fetch_count, 16'd4);

      // Stall three cycles at PC 2.
      restart();
      tick();
      tick();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall_pc_next", pc_next, 8'd2);
         tick();
         check("stall_instr", ifid_instr, 32'h2222_2222);
         check("stall_count", fetch_count, 16'd2);
      end
      stall = 1'b0;
      tick();
      check("unstall_instr", ifid_instr, 32'h3333_3333);
      check("unstall_count", fetch_count, 16'd3);

      // Branch overrides stall at PC 1.
      restart();
      tick();
      branch_taken = 1'b1; branch_target = 8'h40; stall = 1'b1;
      #1;
      check("br_pc_next", pc_next, 8'h40);
      tick();
      check("br_bubble", ifid_valid, 1'b0);
      branch_taken = 1'b0; stall = 1'b0;
      tick();
      check("br_target_instr", ifid_instr, 32'h4040_4040);
      check("br_target_pc1", ifid_pc_plus1, 8'h41);

      // Branch out of the halted state.
      restart();
      for (int i = 0; i < 6; i++) tick();
      check("halt_again", halted, 1'b1);
      branch_taken = 1'b1; branch_target = 8'h10;
      tick();
      check("unhalt_flag", halted, 1'b0);
      check("unhalt_bubble", ifid_valid, 1'b0);
      branch_taken = 1'b0;
      tick();
      check("resume_instr", ifid_instr, 32'h1010_1010);
      check("resume_pc1", ifid_pc_plus1, 8'h11);

      // PC wrap and read-during-write on the same address.
      follow = 1'b0;
      pc_in = 8'hFF;
      #1;
      check("wrap_pc_next", pc_next, 8'h00);
      tick();
      check("wrap_pc1", ifid_pc_plus1, 8'h00);
      pc_in = 8'd5; wr_en = 1'b1; wr_addr = 8'd5; wr_data = 32'hAAAA_AAAA;
      tick();
      check("rdw_old", ifid_instr, 32'h5555_5555);
      wr_en = 1'b0;
      tick();
      check("rdw_new", ifid_instr, 32'hAAAA_AAAA);

      // Reset mid-run wins over branch and stall.
      reset = 1'b0; branch_taken = 1'b1; stall = 1'b1; branch_target = 8'h33;
      tick();
      check("mid_rst_instr", ifid_instr, 32'h0);
      check("mid_rst_pc1", ifid_pc_plus1, 8'h00);
      check("mid_rst_valid", ifid_valid, 1'b0);
      check("mid_rst_halted", halted, 1'b0);
      check("mid_rst_count", fetch_count, 16'd0);
      reset = 1'b1; branch_taken = 1'b0; stall = 1'b0;
      follow = 1'b1;

      // Randomized traffic, compared every cycle against the model.
      for (int i = 0; i < 2000; i++) begin
         tick();
         reset         = ($urandom_range(99) != 0);
         stall         = ($urandom_range(3) == 0);
         branch_taken  = ($urandom_range(9) == 0);
         branch_target = W'($urandom);
         wr_en         = ($urandom_range(4) == 0);
         wr_addr       = W'($urandom);
         wr_data       = ($urandom_range(7) == 0) ? {6'h3F, 26'($urandom)} : $urandom;
         if ($urandom_range(3) == 0) pc_in = W'($urandom);
      end
      tick();
      tick();
      cmp_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
